spi_flash_target: RTL and testbench

SPI_FLASH_TARGET -- requirements
Module: spi_flash_target

---
 rtl/spi_flash_target_if.sv | 14 +
 rtl/spi_flash_target.sv | 185 ++++++++++++++++++
 tb/tb_spi_flash_target.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_target_if.sv
// SPI serial bus between an initiator and the flash target.
//   spi_clk : SPI clock, mode 0, idle low        (initiator -> target)
//   spi_cs  : chip select, active low            (initiator -> target)
//   spi_di  : serial data into target, MSB first (initiator -> target)
//   spi_do  : serial data out of target, MSB first (target -> initiator)
interface spi_flash_target_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_di;
  logic spi_do;

  modport master (output spi_clk, output spi_cs, output spi_di, input spi_do);
  modport slave  (input spi_clk, input spi_cs, input spi_di, output spi_do);
endinterface

// File: rtl/spi_flash_target.sv
// SPI flash target model: RDSR, WREN, WRDI, READ and PP on a small internal
// byte memory, with a timed write-in-progress phase after each page program.
//   clk_i   : system clock (SPI pins are oversampled on it)
//   rst_ni  : asynchronous active-low reset
//   spi     : SPI bus, slave side
//   busy_o  : status bit 0 (WIP)
//   wel_o   : status bit 1 (WEL)
module spi_flash_target #(
  parameter int DEPTH       = 256,
  parameter int PROG_CYCLES = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  spi_flash_target_if.slave spi,
  output logic          busy_o,
  output logic          wel_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PROG_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE} state_t;

  state_t          state, state_n;
  logic [1:0]      clk_sync, cs_sync, di_sync, sync_vld;
  logic            sclk_q, armed;
  logic            sclk_s, cs_s, di_s, rise, fall;
  logic [4:0]      bit_cnt;
  logic [2:0]      obit;
  logic [6:0]      sr;
  logic [7:0]      in_byte, rd_byte, stat_byte;
  logic [AW-1:0]   addr;
  logic            is_pp, wrote, do_r, wip, wel;
  logic [CW-1:0]   wip_cnt;
  logic            set_wel, clr_wel, mem_we;

  // Stored inverted so a zero-initialised array reads back as erased (0xFF).
  logic [7:0]      mem_n [DEPTH];

  // Pin synchronizers. sync_vld masks the reset-forced cs=1 so that only a
  // genuinely sampled high chip select arms the target for a new frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync <= 2'b00;
      cs_sync  <= 2'b11;
      di_sync  <= 2'b00;
      sync_vld <= 2'b00;
      sclk_q   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], spi.spi_clk};
      cs_sync  <= {cs_sync[0], spi.spi_cs};
      di_sync  <= {di_sync[0], spi.spi_di};
      sync_vld <= {sync_vld[0], 1'b1};
      sclk_q   <= clk_sync[1];
      if (sync_vld[1] && cs_sync[1]) armed <= 1'b1;
    end
  end

  assign sclk_s    = clk_sync[1];
  assign cs_s      = cs_sync[1];
  assign di_s      = di_sync[1];
  assign rise      = sclk_s & ~sclk_q;
  assign fall      = ~sclk_s & sclk_q;
  assign in_byte   = {sr, di_s};
  assign rd_byte   = ~mem_n[addr];
  assign stat_byte = {6'b0, wel, wip};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    set_wel = 1'b0;
    clr_wel = 1'b0;
    mem_we  = 1'b0;
    if (cs_s) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (armed) state_n = CMD;
        CMD: if (rise && bit_cnt == 5'd7) begin
          if (in_byte == 8'h05)  state_n = STATUS;  // allowed while busy
          else if (wip)          state_n = IGNORE;
          else begin
            state_n = IGNORE;
            case (in_byte)
              8'h06: set_wel = 1'b1;
              8'h04: clr_wel = 1'b1;
              8'h03: state_n = ADDR;
              8'h02: if (wel) state_n = ADDR;
              default: ;
            endcase
          end
        end
        ADDR: if (rise && bit_cnt == 5'd23) state_n = is_pp ? WR_DATA : RD_DATA;
        WR_DATA: mem_we = rise && bit_cnt == 5'd7;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt <= '0;
      obit    <= '0;
      sr      <= '0;
      addr    <= '0;
      is_pp   <= 1'b0;
      wrote   <= 1'b0;
      do_r    <= 1'b1;
      wip     <= 1'b0;
      wel     <= 1'b0;
      wip_cnt <= '0;
    end else begin
      if (wip) begin
        wip_cnt <= wip_cnt - 1'b1;
        if (wip_cnt <= CW'(1)) begin
          wip <= 1'b0;
          wel <= 1'b0;
        end
      end
      if (set_wel) wel <= 1'b1;
      if (clr_wel) wel <= 1'b0;

      if (cs_s) begin
        bit_cnt <= '0;
        obit    <= '0;
        do_r    <= 1'b1;
        wrote   <= 1'b0;
        if (state == WR_DATA && wrote) begin
          wip     <= 1'b1;
          wip_cnt <= CW'(PROG_CYCLES);
        end
      end else begin
        if (rise) begin
          sr <= in_byte[6:0];
          case (state)
            CMD: begin
              bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) is_pp <= (in_byte == 8'h02);
            end
            ADDR: begin
              // Shifting all 24 bits through an AW-wide register keeps only
              // the low address bits.
              addr    <= {addr[AW-2:0], di_s};
              bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
            end
            WR_DATA: begin
              bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                addr  <= addr + 1'b1;
                wrote <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (fall) begin
          case (state)
            RD_DATA: begin
              do_r <= rd_byte[~obit];  // ~obit == 7-obit: MSB first
              obit <= obit + 3'd1;
              if (obit == 3'd7) addr <= addr + 1'b1;
            end
            STATUS: begin
              do_r <= stat_byte[~obit];
              obit <= obit + 3'd1;
            end
            default: do_r <= 1'b1;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_n[addr] <= ~in_byte;
  end

  assign spi.spi_do = do_r;
  assign busy_o     = wip;
  assign wel_o      = wel;
endmodule

// File: tb/tb_spi_flash_target.sv
// Directed bench: a default instance plus a long-program instance sharing
// the same SPI stimulus, so commands can be issued while WIP is still set.
module tb_spi_flash_target;
  localparam int HP = 5;  // SPI half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_flash_target_if sif ();
  spi_flash_target_if sif2 ();
  assign sif2.spi_clk = sif.spi_clk;
  assign sif2.spi_cs  = sif.spi_cs;
  assign sif2.spi_di  = sif.spi_di;

  logic busy, wel, busy2, wel2;

  spi_flash_target dut (
    .clk_i(clk), .rst_ni(rst_n), .spi(sif), .busy_o(busy), .wel_o(wel));

  spi_flash_target #(.DEPTH(256), .PROG_CYCLES(2000)) dut_long (
    .clk_i(clk), .rst_ni(rst_n), .spi(sif2), .busy_o(busy2), .wel_o(wel2));

  int npass = 0;
  int ntot  = 0;
  int nbusy;
  logic [7:0] r, r2;
  logic [7:0] rb [3];
  logic [7:0] rb2 [3];
  logic [7:0] wb [2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] rx2);
    for (int i = 7; i >= 0; i--) begin
      sif.spi_di = tx[i];
      repeat (HP) @(negedge clk);
      sif.spi_clk = 1'b1;
      rx[i]  = sif.spi_do;
      rx2[i] = sif2.spi_do;
      repeat (HP) @(negedge clk);
      sif.spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    sif.spi_cs = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HP) @(negedge clk);
    sif.spi_cs = 1'b1;
    repeat (2*HP) @(negedge clk);
  endtask

  task automatic one_byte(input logic [7:0] c);
    cs_low();
    xfer(c, r, r2);
    cs_high();
  endtask

  task automatic rdsr(output logic [7:0] s, output logic [7:0] s2);
    cs_low();
    xfer(8'h05, s, s2);
    xfer(8'h00, s, s2);
    cs_high();
  endtask

  task automatic rd(input logic [23:0] a, input int n);
    cs_low();
    xfer(8'h03, r, r2);
    xfer(a[23:16], r, r2);
    xfer(a[15:8], r, r2);
    xfer(a[7:0], r, r2);
    for (int i = 0; i < n; i++) xfer(8'h00, rb[i], rb2[i]);
    cs_high();
  endtask

  // Page program, then count clk cycles with busy_o high after CS rises.
  task automatic pp(input logic [23:0] a, input int n);
    cs_low();
    xfer(8'h02, r, r2);
    xfer(a[23:16], r, r2);
    xfer(a[15:8], r, r2);
    xfer(a[7:0], r, r2);
    for (int i = 0; i < n; i++) xfer(wb[i], r, r2);
    repeat (HP) @(negedge clk);
    sif.spi_cs = 1'b1;
    nbusy = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
  endtask

  initial begin
    sif.spi_clk = 1'b0;
    sif.spi_cs  = 1'b1;
    sif.spi_di  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_do", sif.spi_do, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_wel", wel, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // status after reset, repeated
    cs_low();
    xfer(8'h05, r, r2);
    xfer(8'h00, r, r2);
    check("rdsr_b0", r, 8'h00);
    xfer(8'h00, r, r2);
    check("rdsr_b1", r, 8'h00);
    cs_high();

    // WREN
    one_byte(8'h06);
    check("wren_wel", wel, 1'b1);
    rdsr(r, r2);
    check("rdsr_wel", r, 8'h02);

    // PP A5 3C at 0x10
    wb[0] = 8'hA5; wb[1] = 8'h3C;
    pp(24'h000010, 2);
    check("pp_busy_cycles", nbusy[15:0], 16'd64);
    check("pp_busy_end", busy, 1'b0);
    check("pp_wel_end", wel, 1'b0);
    rd(24'h000010, 3);
    check("rd10_0", rb[0], 8'hA5);
    check("rd10_1", rb[1], 8'h3C);
    check("rd10_2", rb[2], 8'hFF);
    rd(24'h0A0010, 1);
    check("rd_hi_addr_ignored", rb[0], 8'hA5);

    // PP without WREN
    wb[0] = 8'h11; wb[1] = 8'h22;
    pp(24'h000020, 2);
    check("nowel_busy", nbusy[15:0], 16'd0);
    rd(24'h000020, 2);
    check("nowel_rd0", rb[0], 8'hFF);
    check("nowel_rd1", rb[1], 8'hFF);

    // PP across the wrap point
    one_byte(8'h06);
    wb[0] = 8'h01; wb[1] = 8'h02;
    pp(24'h0000FF, 2);
    check("wrap_busy_cycles", nbusy[15:0], 16'd64);
    rd(24'h0000FF, 2);
    check("wrap_rd_ff", rb[0], 8'h01);
    check("wrap_rd_00", rb[1], 8'h02);
    rd(24'h000000, 1);
    check("wrap_rd0", rb[0], 8'h02);

    // long instance: let earlier program finish, then program again
    for (int i = 0; i < 3000 && busy2; i++) @(negedge clk);
    check("long_idle", busy2, 1'b0);
    one_byte(8'h06);
    wb[0] = 8'h77;
    pp(24'h000040, 1);
    check("long_busy", busy2, 1'b1);
    check("long_wel", wel2, 1'b1);
    rd(24'h000040, 1);
    check("rd40_short", rb[0], 8'h77);
    check("rd_during_wip", rb2[0], 8'hFF);
    rdsr(r, r2);
    check("rdsr_during_wip", r2, 8'h03);

    // reset in the middle of a READ of 0xA5
    cs_low();
    xfer(8'h03, r, r2);
    xfer(8'h00, r, r2);
    xfer(8'h00, r, r2);
    xfer(8'h10, r, r2);
    sif.spi_di = 1'b0;
    repeat (HP) @(negedge clk);
    sif.spi_clk = 1'b1;
    check("midrd_bit7", sif.spi_do, 1'b1);
    repeat (HP) @(negedge clk);
    sif.spi_clk = 1'b0;
    repeat (HP) @(negedge clk);
    check("midrd_bit6", sif.spi_do, 1'b0);
    check("midrd_busy2", busy2, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_do", sif.spi_do, 1'b1);
    check("rst_mid_do2", sif2.spi_do, 1'b1);
    check("rst_mid_busy2", busy2, 1'b0);
    check("rst_mid_wel2", wel2, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // CS never went high since reset: frame must be ignored
    xfer(8'h05, r, r2);
    xfer(8'h00, r, r2);
    check("unarmed_frame", r, 8'hFF);
    cs_high();
    rdsr(r, r2);
    check("post_rst_rdsr", r, 8'h00);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
